// File: rtl/uart_xintf_pkg.sv
// Shared constants and state encodings for the UART-to-XINTF bridge.
// The bridge receives frames on the UART and buffers them for reads from the DSP side.
package uart_xintf_pkg;

    localparam int         DEF_CLK_HZ      = 50_000_000;
    localparam int         DEF_BAUD        = 115_200;
    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         FRAME_WORDS_MIN = 2;
    localparam int         FRAME_WORDS_MAX = 32;

    typedef enum logic [1:0] {HUNT, LO, HI, DROP} frm_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: synchronises rxd, times bits with a down-counter, and shifts in 8N1 characters.
// byte_vld or stop_err pulses for one cycle at the middle of the stop bit.
module uart_rx_byte
    import uart_xintf_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int              CW       = $clog2(DIV);
    localparam logic [CW-1:0]   FULL_BIT = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_BIT = CW'(DIV / 2 - 1);

    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic          rxd_meta, rxd_sync, rxd_prev;
    logic          fall;

    assign fall      = rxd_prev & ~rxd_sync;
    assign byte_data = shift;

    // Sync flops reset to the idle-high line level so reset never fakes a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            shift    <= '0;
            bit_idx  <= '0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shift    <= shift_nxt;
            bit_idx  <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift;
        bit_nxt   = bit_idx;
        byte_vld  = 1'b0;
        stop_err  = 1'b0;
        if (state != RX_IDLE && cnt != '0)
            cnt_nxt = cnt - CW'(1);
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    state_nxt = RX_START;
                    cnt_nxt   = HALF_BIT;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (!rxd_sync) begin
                        state_nxt = RX_DATA;
                        cnt_nxt   = FULL_BIT;
                        bit_nxt   = 3'd0;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shift_nxt = {rxd_sync, shift[7:1]};
                    cnt_nxt   = FULL_BIT;
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    state_nxt = RX_IDLE;
                    byte_vld  = rxd_sync;
                    stop_err  = ~rxd_sync;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_frame_rx_buf.sv
// Receive stage of the UART-to-XINTF bridge: it frames SYNC-led byte pairs into 16-bit words and buffers whole frames.
// Words of a frame become readable only after the whole frame has arrived and been committed.
module uart_frame_rx_buf
    import uart_xintf_pkg::*;
#(
    parameter int         CLK_HZ      = DEF_CLK_HZ,
    parameter int         BAUD        = DEF_BAUD,
    parameter int         FRAME_WORDS = 8,
    parameter int         FIFO_AW     = 6,
    parameter logic [7:0] SYNC_BYTE   = uart_xintf_pkg::SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rxd,
    input  logic               rd_stb,
    output logic [15:0]        rd_data,
    output logic               xrd_req,
    output logic [FIFO_AW:0]   frame_cnt,
    output logic               ovf,
    output logic               ferr,
    output logic               udf
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int WCW   = $clog2(FRAME_WORDS + 1);
    localparam int DCW   = $clog2(2 * FRAME_WORDS + 1);

    typedef logic [FIFO_AW:0] ptr_t;

    logic [15:0]    mem [DEPTH];
    ptr_t           wr_ptr, rd_ptr, commit_ptr, frm_start, used;
    frm_state_t     state, state_nxt;
    logic [7:0]     lo_byte;
    logic [15:0]    wr_word;
    logic [WCW-1:0] wr_left, rd_left;
    logic [DCW-1:0] drop_left;
    logic           wr_pend, commit_pend;
    logic           byte_vld, stop_err;
    logic [7:0]     byte_data;
    logic           space_ok, rd_avail, rd_ok, frm_inc, frm_dec;
    logic           start_frm, set_ovf, lo_ld, hi_wr, abort;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .stop_err  (stop_err)
    );

    // Free space counts uncommitted words too, since wr_ptr already covers them
    assign used     = wr_ptr - rd_ptr;
    assign space_ok = (ptr_t'(DEPTH) - used) >= ptr_t'(FRAME_WORDS);
    assign rd_avail = (rd_ptr != commit_ptr);
    assign rd_ok    = rd_stb & rd_avail;
    assign frm_inc  = wr_pend & commit_pend;
    assign frm_dec  = rd_ok & (rd_left == WCW'(1));
    assign xrd_req  = (frame_cnt != '0);

    always_comb begin
        state_nxt = state;
        start_frm = 1'b0;
        set_ovf   = 1'b0;
        lo_ld     = 1'b0;
        hi_wr     = 1'b0;
        abort     = 1'b0;
        case (state)
            HUNT: begin
                if (byte_vld && byte_data == SYNC_BYTE) begin
                    if (space_ok) begin
                        start_frm = 1'b1;
                        state_nxt = LO;
                    end else begin
                        set_ovf   = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            LO: begin
                if (stop_err) begin
                    abort     = 1'b1;
                    state_nxt = HUNT;
                end else if (byte_vld) begin
                    lo_ld     = 1'b1;
                    state_nxt = HI;
                end
            end
            HI: begin
                if (stop_err) begin
                    abort     = 1'b1;
                    state_nxt = HUNT;
                end else if (byte_vld) begin
                    hi_wr     = 1'b1;
                    state_nxt = (wr_left == WCW'(1)) ? HUNT : LO;
                end
            end
            DROP: begin
                if (byte_vld && drop_left == DCW'(1))
                    state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            commit_ptr  <= '0;
            frm_start   <= '0;
            lo_byte     <= '0;
            wr_word     <= '0;
            wr_left     <= WCW'(FRAME_WORDS);
            rd_left     <= WCW'(FRAME_WORDS);
            drop_left   <= '0;
            wr_pend     <= 1'b0;
            commit_pend <= 1'b0;
            rd_data     <= '0;
            frame_cnt   <= '0;
            ovf         <= 1'b0;
            ferr        <= 1'b0;
            udf         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (stop_err)
                ferr <= 1'b1;
            if (set_ovf)
                ovf <= 1'b1;
            if (rd_stb && !rd_avail)
                udf <= 1'b1;

            if (start_frm) begin
                frm_start <= wr_ptr;
                wr_left   <= WCW'(FRAME_WORDS);
            end
            if (set_ovf)
                drop_left <= DCW'(2 * FRAME_WORDS);
            else if (state == DROP && byte_vld)
                drop_left <= drop_left - DCW'(1);
            if (lo_ld)
                lo_byte <= byte_data;

            // Word write and commit land one cycle after the HI byte
            wr_pend     <= hi_wr;
            commit_pend <= hi_wr & (wr_left == WCW'(1));
            if (hi_wr) begin
                wr_word <= {byte_data, lo_byte};
                wr_left <= wr_left - WCW'(1);
            end
            if (abort)
                wr_ptr <= frm_start;
            else if (wr_pend)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (frm_inc)
                commit_ptr <= wr_ptr + ptr_t'(1);

            if (rd_ok) begin
                rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
                rd_ptr  <= rd_ptr + ptr_t'(1);
                rd_left <= (rd_left == WCW'(1)) ? WCW'(FRAME_WORDS) : rd_left - WCW'(1);
            end

            if (frm_inc && !frm_dec)
                frame_cnt <= frame_cnt + 1'b1;
            else if (frm_dec && !frm_inc)
                frame_cnt <= frame_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pend)
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_word;
    end

endmodule
